// File: rtl/simple_decoder_pkg.sv
// Shared types for the stream decoder and its pattern event collector.
// NUM_PAT must match the decoder's pattern output count.
package simple_decoder_pkg;

  localparam int NUM_PAT = 4;

  typedef logic [NUM_PAT-1:0] pat_vec_t;

  typedef enum logic {
    IDLE,
    COUNT
  } collector_state_t;

endpackage

// File: rtl/pattern_sat_counter.sv
// Per-pattern hit counter that saturates at all-ones.
// Clear has priority over increment.
module pattern_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_event_collector.sv
// Windowed per-pattern hit accumulation with a single-entry
// report buffer; records that find the buffer busy are counted as drops.
module pattern_event_collector #(
  parameter int NUM_PAT = simple_decoder_pkg::NUM_PAT,
  parameter int CNT_W   = 8,
  parameter int WINDOW  = 256,
  parameter int WIN_W   = $clog2(WINDOW + 1)
) (
  input  logic                     clk_i,
  input  logic                     rstn_clk_ni,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic [NUM_PAT-1:0]       pattern_i,
  output logic                     report_valid_o,
  input  logic                     report_ready_i,
  output logic [NUM_PAT*CNT_W-1:0] report_cnt_o,
  output logic [WIN_W-1:0]         report_len_o,
  output logic [CNT_W-1:0]         drop_cnt_o
);

  import simple_decoder_pkg::*;

  collector_state_t state;
  collector_state_t state_nx;

  logic [WIN_W-1:0]         win_cnt;
  logic                     counting;
  logic                     close;
  logic                     clear;
  logic                     buf_free;
  logic [NUM_PAT*CNT_W-1:0] cnt_flat;
  logic [NUM_PAT*CNT_W-1:0] cnt_close;

  assign counting = (state == COUNT) && en_i;
  assign close    = counting &&
                    (flush_i || (win_cnt == WIN_W'(WINDOW - 1)));
  assign clear    = !counting || close;
  assign buf_free = !report_valid_o || report_ready_i;

  // Record must include the closing cycle's hits, so form it
  // from the counter value plus this cycle's flag.
  for (genvar k = 0; k < NUM_PAT; k++) begin : g_pat
    pattern_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk_i),
      .rst_n(rstn_clk_ni),
      .clear(clear),
      .inc  (counting && pattern_i[k]),
      .count(cnt_flat[k*CNT_W +: CNT_W])
    );

    assign cnt_close[k*CNT_W +: CNT_W] =
      (pattern_i[k] && !(&cnt_flat[k*CNT_W +: CNT_W])) ?
      cnt_flat[k*CNT_W +: CNT_W] + 1'b1 :
      cnt_flat[k*CNT_W +: CNT_W];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en_i)  state_nx = COUNT;
      COUNT:   if (!en_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_clk_ni) begin
    if (!rstn_clk_ni) begin
      state   <= IDLE;
      win_cnt <= '0;
    end else begin
      state   <= state_nx;
      win_cnt <= clear ? '0 : win_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_clk_ni) begin
    if (!rstn_clk_ni) begin
      report_valid_o <= 1'b0;
      report_cnt_o   <= '0;
      report_len_o   <= '0;
      drop_cnt_o     <= '0;
    end else begin
      if (close && buf_free) begin
        report_valid_o <= 1'b1;
        report_cnt_o   <= cnt_close;
        report_len_o   <= win_cnt + 1'b1;
      end else if (report_ready_i) begin
        report_valid_o <= 1'b0;
      end
      if (close && !buf_free && (drop_cnt_o != '1)) begin
        drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_event_collector.sv
// Bench for pattern_event_collector: directed phases plus random
// traffic, compared against a window-level behavioural model.
module tb_pattern_event_collector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] pat = '0;

  logic        v8;
  logic [31:0] c8;
  logic [3:0]  l8;
  logic [7:0]  d8;
  logic        v3;
  logic [31:0] c3;
  logic [8:0]  l3;
  logic [7:0]  d3;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: window activity, raw hit totals, buffered record
  bit          m_act;
  bit          m_v;
  int          m_hit[4];
  int          m_cyc;
  logic [31:0] m_cnt;
  int          m_len;
  int          m_drop;

  always #5 clk = ~clk;

  pattern_event_collector #(.WINDOW(8)) u_d8 (
    .clk_i         (clk),
    .rstn_clk_ni   (rst_n),
    .en_i          (en),
    .flush_i       (flush),
    .pattern_i     (pat),
    .report_valid_o(v8),
    .report_ready_i(ready),
    .report_cnt_o  (c8),
    .report_len_o  (l8),
    .drop_cnt_o    (d8)
  );

  pattern_event_collector #(.WINDOW(300)) u_d300 (
    .clk_i         (clk),
    .rstn_clk_ni   (rst_n),
    .en_i          (en),
    .flush_i       (flush),
    .pattern_i     (pat),
    .report_valid_o(v3),
    .report_ready_i(ready),
    .report_cnt_o  (c3),
    .report_len_o  (l3),
    .drop_cnt_o    (d3)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    m_act  = 0;
    m_v    = 0;
    m_cyc  = 0;
    m_cnt  = '0;
    m_len  = 0;
    m_drop = 0;
    for (int k = 0; k < 4; k++) m_hit[k] = 0;
  endfunction

  function automatic void m_step();
    if (m_v && ready) m_v = 0;
    if (!m_act) begin
      if (en) begin
        m_act = 1;
        m_cyc = 0;
        for (int k = 0; k < 4; k++) m_hit[k] = 0;
      end
    end else if (!en) begin
      m_act = 0;
    end else begin
      for (int k = 0; k < 4; k++) m_hit[k] += int'(pat[k]);
      m_cyc++;
      if (m_cyc == 8 || flush) begin
        if (!m_v) begin
          m_v   = 1;
          m_len = m_cyc;
          for (int k = 0; k < 4; k++)
            m_cnt[k*8 +: 8] = 8'((m_hit[k] > 255) ? 255 : m_hit[k]);
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_cyc = 0;
        for (int k = 0; k < 4; k++) m_hit[k] = 0;
      end
    end
  endfunction

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    chk("model_valid", 32'(v8), 32'(m_v));
    if (m_v) begin
      chk("model_cnt", c8, m_cnt);
      chk("model_len", 32'(l8), 32'(m_len));
    end
    chk("model_drop", 32'(d8), 32'(m_drop));
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_v8"}, 32'(v8), 0);
    chk({tag, "_c8"}, c8, 0);
    chk({tag, "_l8"}, 32'(l8), 0);
    chk({tag, "_d8"}, 32'(d8), 0);
    chk({tag, "_v3"}, 32'(v3), 0);
    chk({tag, "_c3"}, c3, 0);
    chk({tag, "_l3"}, 32'(l3), 0);
    chk({tag, "_d3"}, 32'(d3), 0);
  endtask

  task automatic rand_in();
    en    = 1'($urandom);
    flush = 1'($urandom);
    ready = 1'($urandom);
    pat   = 4'($urandom);
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    m_reset();

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      rand_in();
      @(posedge clk);
      #1;
    end
    all_zero("rst");
    en = 0; flush = 0; ready = 0; pat = '0;
    rst_n = 1'b1;

    // saturation on the 300-cycle instance
    en = 1; ready = 1; pat = 4'b0100;
    n = 0;
    while (!v3 && n < 320) begin
      step();
      n++;
    end
    chk("sat_steps", 32'(n), 301);
    chk("sat_cnt", c3, 32'h00FF_0000);
    chk("sat_len", 32'(l3), 300);

    rst_n = 1'b0;
    en = 0; pat = '0; ready = 0;
    #3;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic window: 3 hits on p0, 1 hit on p3
    ready = 1; en = 1;
    step();
    for (int i = 1; i <= 8; i++) begin
      pat = (i <= 3) ? 4'b0001 : ((i == 4) ? 4'b1000 : 4'b0000);
      step();
      if (i < 8) chk("basic_early", 32'(v8), 0);
    end
    chk("basic_valid", 32'(v8), 1);
    chk("basic_cnt", c8, 32'h0100_0003);
    chk("basic_len", 32'(l8), 8);
    pat = '0;

    // backpressure: hold A, drop B, replace with C on accept
    en = 0;
    step();
    step();
    en = 1; ready = 0;
    step();
    pat = 4'b0001;
    repeat (8) step();
    held = c8;
    chk("bp_a_cnt", held, 32'h0000_0008);
    for (int i = 0; i < 8; i++) begin
      pat = 4'($urandom);
      step();
      chk("bp_hold_cnt", c8, 32'h0000_0008);
      chk("bp_hold_len", 32'(l8), 8);
    end
    chk("bp_drop", 32'(d8), 1);
    pat = 4'b0010;
    repeat (7) step();
    ready = 1;
    step();
    chk("bp_c_valid", 32'(v8), 1);
    chk("bp_c_cnt", c8, 32'h0000_0800);
    pat = '0;

    // flush on third counted cycle
    en = 0;
    step();
    step();
    en = 1;
    step();
    for (int i = 1; i <= 3; i++) begin
      pat = 4'($urandom);
      flush = (i == 3);
      step();
    end
    flush = 0;
    chk("flush_valid", 32'(v8), 1);
    chk("flush_len", 32'(l8), 3);
    for (int i = 1; i <= 8; i++) begin
      pat = 4'($urandom);
      step();
      if (i == 7) chk("flush_next_early", 32'(v8), 0);
    end
    chk("flush_next_valid", 32'(v8), 1);
    chk("flush_next_len", 32'(l8), 8);

    // abort on 5th counted cycle, then fresh window
    en = 0; pat = '0;
    step();
    step();
    en = 1; pat = 4'hF;
    step();
    repeat (4) step();
    en = 0;
    step();
    repeat (10) begin
      step();
      chk("abort_none", 32'(v8), 0);
    end
    en = 1; pat = '0;
    step();
    for (int i = 1; i <= 8; i++) begin
      pat = (i <= 2) ? 4'b0100 : 4'b0000;
      step();
    end
    chk("abort_cnt", c8, 32'h0002_0000);
    chk("abort_len", 32'(l8), 8);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 15) != 0);
      flush = ($urandom_range(0, 9) == 0);
      ready = 1'($urandom);
      pat   = 4'($urandom);
      step();
    end

    // async reset while a record is pending
    en = 1; flush = 0; ready = 0;
    n = 0;
    while (!v8 && n < 20) begin
      step();
      n++;
    end
    chk("pre_rst_valid", 32'(v8), 1);
    chk("pre_rst_drop_nz", 32'(d8 != 0), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v8), 0);
    chk("arst_drop", 32'(d8), 0);
    chk("arst_cnt", c8, 0);
    chk("arst_len", 32'(l8), 0);
    m_reset();
    for (int i = 0; i < 3; i++) begin
      rand_in();
      @(posedge clk);
      #1;
    end
    all_zero("rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
